// File: rtl/stage_if.sv
// Instruction-fetch stage: sequential PC, one outstanding memory read, a
// registered output slot (if_*) backed by a one-entry skid buffer, and
// redirect handling that flushes in-flight and buffered instructions.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALN = RESET_PC & ALIGN_MASK;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic        out_vld_q, out_vld_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;

    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        redirect;
    logic        consume;
    logic        deliver;
    logic [31:0] br_target;

    // A redirect only counts when decode is actually advancing this cycle.
    assign redirect  = br & ~stall;
    assign consume   = out_vld_q & ~stall;
    assign br_target = br_addr & ALIGN_MASK;

    // Fetch FSM next-state, PC update and memory request generation.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        mem_req  = 1'b0;
        mem_addr = pc_q;
        deliver  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Only issue while the skid has room for the returning word.
                mem_req = ~rst & ~skid_vld_q & ~redirect;
                if (redirect) begin
                    pc_d = br_target;
                end else if (mem_req && mem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d = br_target;
                    // Same-cycle data is stale; otherwise drain it in KILL.
                    state_d = mem_rvalid ? ST_FETCH : ST_KILL;
                end else if (mem_rvalid) begin
                    deliver = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (redirect) begin
                    pc_d = br_target;
                end
                // The pending response is being discarded; once it shows up
                // nothing is outstanding, so fetching may resume even if a new
                // redirect arrives in the same cycle.
                if (mem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output slot and skid buffer: skid drains first so fetch order is kept.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        skid_vld_d  = skid_vld_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (redirect) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || consume) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_pc_d   = skid_pc_q;
                out_inst_d = skid_inst_q;
                if (deliver) begin
                    skid_pc_d   = req_pc_q;
                    skid_inst_d = mem_rdata;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end else if (deliver) begin
                out_vld_d  = 1'b1;
                out_pc_d   = req_pc_q;
                out_inst_d = mem_rdata;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (deliver) begin
            skid_vld_d  = 1'b1;
            skid_pc_d   = req_pc_q;
            skid_inst_d = mem_rdata;
        end
    end

    // Control state and the visible output register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC_ALN;
            out_vld_q  <= 1'b0;
            out_pc_q   <= 32'h0;
            out_inst_q <= 32'h0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_vld_q  <= out_vld_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Datapath holding registers; their contents are qualified by valid bits.
    always_ff @(posedge clk) begin
        req_pc_q    <= req_pc_d;
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end

    assign if_valid = out_vld_q;
    assign if_pc    = out_pc_q;
    assign if_inst  = out_inst_q;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios plus a randomized run
// checked against an in-order fetch-stream model with a simple memory.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [31:0] br_addr;
    logic        mem_req, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    logic        stall2, br2, mem_ready2, mem_rvalid2, mem_req2, if_valid2;
    logic [31:0] br_addr2, mem_rdata2, mem_addr2, if_pc2, if_inst2;

    int errors = 0;
    int checks = 0;

    // Bench memory: one pending response with a countdown.
    logic        pend_v;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat;

    always #5 clk = ~clk;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    stage_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall2), .br(br2), .br_addr(br_addr2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ready(mem_ready2),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_inst(if_inst2)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
    endfunction

    task automatic drive_mem();
        mem_rvalid = pend_v && (pend_cnt == 1);
        mem_rdata  = mem_rvalid ? inst_of(pend_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic update_mem();
        if (pend_v) begin
            if (pend_cnt <= 1) pend_v = 1'b0;
            else pend_cnt = pend_cnt - 1;
        end
        if (mem_req && mem_ready) begin
            pend_v    = 1'b1;
            pend_addr = mem_addr;
            pend_cnt  = lat;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = 32'h0; mem_ready = 1'b0;
        pend_v = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        stall2 = 1'b0; br2 = 1'b0; br_addr2 = 32'h0; mem_ready2 = 1'b0;
        mem_rvalid2 = 1'b0; mem_rdata2 = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic        exp_v;
        logic [31:0] exp_pc;
        do_reset();
        lat = 1; mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_mem();
            #1;
            exp_v = (c >= 2) && (c % 2 == 0);
            checks++;
            if (if_valid !== exp_v) begin
                errors++;
                $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, if_valid, exp_v);
            end
            checks++;
            if (mem_req !== (c % 2 == 0)) begin
                errors++;
                $display("FAIL basic_req c=%0d got=%0b", c, mem_req);
            end
            if (c % 2 == 0) begin
                checks++;
                if (mem_addr !== 32'(4 * (c / 2))) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d got=%h exp=%h", c, mem_addr, 32'(4 * (c / 2)));
                end
            end
            if (exp_v) begin
                exp_pc = 32'(4 * (c / 2 - 1));
                checks++;
                if (if_pc !== exp_pc || if_inst !== inst_of(exp_pc)) begin
                    errors++;
                    $display("FAIL basic_out c=%0d got=%h/%h exp=%h/%h", c, if_pc, if_inst, exp_pc, inst_of(exp_pc));
                end
            end
            update_mem();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1;
        drive_mem();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_during got=%0b exp=0", mem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%0b pc=%h inst=%h req=%0b exp 0/0/0/0", if_valid, if_pc, if_inst, mem_req);
        end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; pend_v = 1'b0;
        drive_mem();
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got req=%0b addr=%h exp 1/00000000", mem_req, mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int got;
        do_reset();
        lat = 1; mem_ready = 1'b1; stall = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive_mem();
            #1;
            if (c >= 4) begin
                checks++;
                if (mem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== inst_of(32'h0)) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got req=%0b v=%0b pc=%h exp 0/1/00000000", c, mem_req, if_valid, if_pc);
                end
            end
            update_mem();
            @(negedge clk);
        end
        stall = 1'b0;
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            drive_mem();
            #1;
            if (if_valid) begin
                checks++;
                if (if_pc !== 32'(4 * got) || if_inst !== inst_of(32'(4 * got))) begin
                    errors++;
                    $display("FAIL stall_order n=%0d got=%h exp=%h", got, if_pc, 32'(4 * got));
                end
                if (got == 1) begin
                    checks++;
                    if (c !== 1) begin
                        errors++;
                        $display("FAIL stall_skid_move got cycle=%0d exp=1", c);
                    end
                end
                got++;
            end
            update_mem();
            @(negedge clk);
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL stall_timeout got=%0d exp=3", got);
        end
    endtask

    task automatic test_redirect_wait();
        logic seen_req, seen_v;
        do_reset();
        lat = 3; mem_ready = 1'b1;
        drive_mem();
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL redir_first got req=%0b addr=%h", mem_req, mem_addr);
        end
        update_mem();
        @(negedge clk);
        br = 1'b1; br_addr = 32'h100;
        for (int c = 1; c < 4; c++) begin
            drive_mem();
            #1;
            checks++;
            if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_kill c=%0d got req=%0b v=%0b exp 0/0", c, mem_req, if_valid);
            end
            update_mem();
            @(negedge clk);
            br = 1'b0;
        end
        lat = 1;
        seen_req = 1'b0; seen_v = 1'b0;
        for (int c = 0; c < 20 && !seen_v; c++) begin
            drive_mem();
            #1;
            if (mem_req && !seen_req) begin
                seen_req = 1'b1;
                checks++;
                if (mem_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL redir_addr got=%h exp=00000100", mem_addr);
                end
            end
            if (if_valid) begin
                seen_v = 1'b1;
                checks++;
                if (if_pc !== 32'h100 || if_inst !== inst_of(32'h100)) begin
                    errors++;
                    $display("FAIL redir_pc got=%h/%h exp=00000100/%h", if_pc, if_inst, inst_of(32'h100));
                end
            end
            update_mem();
            @(negedge clk);
        end
        checks++;
        if (!seen_v) begin
            errors++;
            $display("FAIL redir_timeout got=none exp=valid");
        end
    endtask

    task automatic test_br_stall();
        do_reset();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL brst_c0 got req=%0b addr=%h", mem_req, mem_addr);
        end
        @(negedge clk);
        stall = 1'b1; br = 1'b1; br_addr = 32'h200;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL brst_ignored got req=%0b addr=%h exp 1/00000000", mem_req, mem_addr);
        end
        @(negedge clk);
        stall = 1'b0; br = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL brst_pc_kept got=%h exp=00000000", mem_addr);
        end
        @(negedge clk);
        br = 1'b1; br_addr = 32'h103; mem_ready = 1'b1;
        drive_mem();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL brst_req_forced got=%0b exp=0", mem_req);
        end
        update_mem();
        @(negedge clk);
        br = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL brst_aligned got req=%0b addr=%h exp 1/00000100", mem_req, mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        mem_ready2 = 1'b1;
        #1;
        checks++;
        if (mem_req2 !== 1'b1 || mem_addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first got req=%0b addr=%h exp 1/fffffffc", mem_req2, mem_addr2);
        end
        @(negedge clk);
        mem_ready2 = 1'b0; mem_rvalid2 = 1'b1; mem_rdata2 = inst_of(32'hFFFF_FFFC);
        #1;
        checks++;
        if (mem_req2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_wait got req=%0b exp=0", mem_req2);
        end
        @(negedge clk);
        mem_rvalid2 = 1'b0;
        #1;
        checks++;
        if (mem_req2 !== 1'b1 || mem_addr2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next got req=%0b addr=%h exp 1/00000000", mem_req2, mem_addr2);
        end
        checks++;
        if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC || if_inst2 !== inst_of(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_out got v=%0b pc=%h exp 1/fffffffc", if_valid2, if_pc2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        do_reset();
        lat = 2; mem_ready = 1'b1;
        drive_mem();
        #1;
        update_mem();
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b1;
        drive_mem();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstw_req got=%0b exp=0", mem_req);
        end
        update_mem();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_mem();
            #1;
            checks++;
            if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
                errors++;
                $display("FAIL rstw_late c=%0d got v=%0b req=%0b addr=%h exp 0/1/00000000", c, if_valid, mem_req, mem_addr);
            end
            update_mem();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch, exp_cons, hold_pc, hold_inst, tgt;
        logic        hold_prev, red;
        int          ncons;
        do_reset();
        exp_fetch = 32'h0; exp_cons = 32'h0; hold_prev = 1'b0; ncons = 0;
        for (int c = 0; c < 3000; c++) begin
            stall     = ($urandom_range(0, 9) < 3);
            br        = ($urandom_range(0, 19) == 0);
            br_addr   = $urandom();
            mem_ready = ($urandom_range(0, 9) < 7);
            lat       = $urandom_range(1, 3);
            drive_mem();
            #1;
            red = br && !stall;
            tgt = br_addr & 32'hFFFF_FFFC;
            if (mem_req) begin
                checks++;
                if (pend_v || red || mem_addr !== exp_fetch) begin
                    errors++;
                    $display("FAIL rnd_req c=%0d got addr=%h pend=%0b red=%0b exp addr=%h", c, mem_addr, pend_v, red, exp_fetch);
                end
            end
            if (hold_prev) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== hold_pc || if_inst !== hold_inst) begin
                    errors++;
                    $display("FAIL rnd_hold c=%0d got v=%0b pc=%h exp 1/%h", c, if_valid, if_pc, hold_pc);
                end
            end
            if (if_valid && !stall) begin
                checks++;
                if (if_pc !== exp_cons || if_inst !== inst_of(exp_cons)) begin
                    errors++;
                    $display("FAIL rnd_order c=%0d got=%h/%h exp=%h/%h", c, if_pc, if_inst, exp_cons, inst_of(exp_cons));
                end
                exp_cons = exp_cons + 32'd4;
                ncons++;
            end
            if (red) begin
                exp_cons  = tgt;
                exp_fetch = tgt;
            end else if (mem_req && mem_ready) begin
                exp_fetch = exp_fetch + 32'd4;
            end
            hold_prev = if_valid && stall;
            hold_pc   = if_pc;
            hold_inst = if_inst;
            update_mem();
            @(negedge clk);
        end
        stall = 1'b0; br = 1'b0; mem_ready = 1'b0;
        checks++;
        if (ncons < 100) begin
            errors++;
            $display("FAIL rnd_progress got=%0d exp>=100", ncons);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = 32'h0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; pend_v = 1'b0; pend_addr = 32'h0;
        pend_cnt = 0; lat = 1;
        stall2 = 1'b0; br2 = 1'b0; br_addr2 = 32'h0; mem_ready2 = 1'b0;
        mem_rvalid2 = 1'b0; mem_rdata2 = 32'h0;
        @(negedge clk);
        test_basic();
        test_reset();
        test_stall();
        test_redirect_wait();
        test_br_stall();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  downstream (IF/ID) cannot accept this cycle.
REQ-005 SHALL have port: br  input  1  redirect request from decode.
REQ-006 SHALL have port: br_addr  input  32  redirect target.
REQ-007 SHALL have port: mem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port: mem_addr  output  32  request address, word aligned.
REQ-009 SHALL have port: mem_ready  input  1  request accepted this cycle.
REQ-010 SHALL have port: mem_rvalid  input  1  read data valid.
REQ-011 SHALL have port: mem_rdata  input  32  read data.
REQ-012 SHALL have port: if_valid  output  1  if_pc/if_inst hold a live instruction.
REQ-013 SHALL have port: if_pc  output  32  PC of presented instruction.
REQ-014 SHALL have port: if_inst  output  32  presented instruction word.

Function
REQ-015 SHALL keep a fetch PC register, a 1-entry output register (if_*) and a 1-entry skid buffer; all outputs registered except mem_req/mem_addr.
REQ-016 SHALL implement states FETCH, WAIT, KILL; at most one memory request outstanding.
REQ-017 FETCH: mem_req=1 and mem_addr=pc only when skid buffer empty; on mem_req&&mem_ready -> latch req_pc=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go WAIT.
REQ-018 WAIT: mem_req=0; on mem_rvalid -> deliver {req_pc, mem_rdata}, go FETCH in the next cycle.
REQ-019 KILL: mem_req=0; on mem_rvalid -> discard data, go FETCH.
REQ-020 mem_rvalid in FETCH SHALL be ignored.
REQ-021 Consume: downstream takes if_* on any edge with if_valid=1 and stall=0.
REQ-022 Delivery: if output register empty or being consumed, load delivered word into it (if_valid=1 next cycle); otherwise write skid buffer.
REQ-023 When output consumed and skid buffer full, skid moves to output same edge; skid entry SHALL take priority over a same-cycle delivery, which then goes to skid.
REQ-024 Order of presented instructions SHALL equal fetch order; no entry lost or duplicated under any stall pattern.
REQ-025 Latency: request accepted cycle N, rvalid cycle N+1 -> if_valid=1 in cycle N+2 (output empty, no stall).
REQ-026 Redirect honoured only when br=1 and stall=0; br while stall=1 SHALL be ignored.
REQ-027 On honoured redirect: pc<={br_addr[31:2],2'b00}; output register and skid buffer invalidated (if_valid=0 next cycle); mem_req forced 0 that cycle.
REQ-028 Redirect in WAIT without same-cycle mem_rvalid -> KILL; redirect in WAIT with same-cycle mem_rvalid -> data discarded, go FETCH.
REQ-029 Redirect in KILL -> stay KILL with new pc; redirect in FETCH -> stay FETCH with new pc, any same-cycle mem_ready ignored.
REQ-030 if_pc/if_inst SHALL hold value while if_valid=1 and stall=1.

Reset
REQ-031 On rst=1 at an edge: pc=RESET_PC, state FETCH, if_valid=0, if_pc=0, if_inst=0, skid empty.
REQ-032 While rst=1, mem_req SHALL be 0; first cycle after rst falls: mem_req=1, mem_addr=RESET_PC.
REQ-033 Reset mid-WAIT SHALL abandon the request; a late mem_rvalid lands in FETCH and is ignored.

Verification
REQ-034 Reset, mem_ready=1, rvalid one cycle after accept, stall=0 -> if_pc sequence 0,4,8 with matching if_inst, one per 2 cycles.
REQ-035 Hold stall=1 for 5 cycles with two words returned -> if_pc=0 held, skid holds 4, mem_req=0; release -> 0 then 4 then 8, none lost.
REQ-036 br=1, br_addr=32'h100 while in WAIT, rvalid 2 cycles later -> stale word discarded, next mem_addr=32'h100, next if_pc=32'h100.
REQ-037 br=1 with stall=1 -> no redirect, pc unchanged; br=1, br_addr=32'h103 with stall=0 -> mem_addr=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
REQ-039 rst pulse during WAIT, rvalid arrives next cycle -> ignored, if_valid stays 0, mem_addr=RESET_PC.
